// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the highway/country intersection sequencer.
//   - light codes driven on the hgwy/cntry heads
//   - phase (state) encoding, also exported on the phase output
//   - default dwell durations and timer width
package traffic_pkg;

    // Signal head codes; code 3 is never driven
    localparam logic [2:0] RED    = 3'd0;
    localparam logic [2:0] YELLOW = 3'd1;
    localparam logic [2:0] GREEN  = 3'd2;

    // Phase encoding
    localparam logic [2:0] HW_GREEN  = 3'd0;
    localparam logic [2:0] HW_YELLOW = 3'd1;
    localparam logic [2:0] ALL_RED_A = 3'd2;
    localparam logic [2:0] CN_GREEN  = 3'd3;
    localparam logic [2:0] CN_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_B = 3'd5;
    localparam logic [2:0] PED_WALK  = 3'd6;

    // Default dwell durations in clk cycles
    localparam int DEF_YEL_CYC    = 6;
    localparam int DEF_ALLRED_CYC = 4;
    localparam int DEF_MIN_HW_CYC = 8;
    localparam int DEF_MAX_CN_CYC = 16;
    localparam int DEF_WALK_CYC   = 10;
    localparam int DEF_TW         = 5;

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// phase_timer: loadable down-counter that times every phase dwell.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset, count returns to RST_VAL
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - value to load (duration - 1)
//   done     - count has reached zero; the counter saturates there
module phase_timer #(
    parameter int              TW      = 5,
    parameter logic [TW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: highway/country crossing sequencer with a
// pedestrian walk phase, country gap-out/max-out and highway-favouring
// emergency preemption.
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   car_sensor  - country-road vehicle present (level)
//   ped_req     - pedestrian button (pulse, any width)
//   emerg_req   - emergency preempt toward the highway (level)
//   hgwy        - highway head code (RED/YELLOW/GREEN)
//   cntry       - country head code (RED/YELLOW/GREEN)
//   walk        - pedestrian walk lamp
//   ped_waiting - pedestrian request latched and not yet served
//   phase       - current state code
//
// state     | meaning
// ----------+-----------------------------------------------------------
// HW_GREEN  | highway green; min dwell, then leaves on demand w/o emerg
// HW_YELLOW | highway yellow
// ALL_RED_A | clearance after highway; picks emerg > ped > country
// CN_GREEN  | country green; gap-out, max-out or emergency ends it
// CN_YELLOW | country yellow
// ALL_RED_B | clearance before highway (also the reset state)
// PED_WALK  | pedestrian walk, both roads red, not preemptable
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int YEL_CYC    = DEF_YEL_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int MIN_HW_CYC = DEF_MIN_HW_CYC,
    parameter int MAX_CN_CYC = DEF_MAX_CN_CYC,
    parameter int WALK_CYC   = DEF_WALK_CYC,
    parameter int TW         = DEF_TW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_sensor,
    input  logic       ped_req,
    input  logic       emerg_req,
    output logic [2:0] hgwy,
    output logic [2:0] cntry,
    output logic       walk,
    output logic       ped_waiting,
    output logic [2:0] phase
);

    localparam logic [TW-1:0] YEL_LD    = TW'(YEL_CYC - 1);
    localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_CYC - 1);
    localparam logic [TW-1:0] MIN_HW_LD = TW'(MIN_HW_CYC - 1);
    localparam logic [TW-1:0] MAX_CN_LD = TW'(MAX_CN_CYC - 1);
    localparam logic [TW-1:0] WALK_LD   = TW'(WALK_CYC - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          ped_pending;
    logic          tdone;
    logic          tload;
    logic [TW-1:0] tload_val;

    always_comb begin
        state_nxt = state;
        case (state)
            HW_GREEN: begin
                // emergency freezes the state; the timer keeps running
                if (tdone && !emerg_req && (car_sensor || ped_pending))
                    state_nxt = HW_YELLOW;
            end
            HW_YELLOW: if (tdone) state_nxt = ALL_RED_A;
            ALL_RED_A: begin
                if (tdone) begin
                    if (emerg_req)        state_nxt = HW_GREEN;
                    else if (ped_pending) state_nxt = PED_WALK;
                    else                  state_nxt = CN_GREEN;
                end
            end
            CN_GREEN: begin
                if (!car_sensor || tdone || emerg_req)
                    state_nxt = CN_YELLOW;
            end
            CN_YELLOW: if (tdone) state_nxt = ALL_RED_B;
            PED_WALK:  if (tdone) state_nxt = ALL_RED_B;
            ALL_RED_B: if (tdone) state_nxt = HW_GREEN;
            default:   state_nxt = ALL_RED_B;
        endcase
    end

    // Timer reloads on every state change with the new state's dwell - 1
    assign tload = (state_nxt != state);

    always_comb begin
        tload_val = ALLRED_LD;
        case (state_nxt)
            HW_GREEN:  tload_val = MIN_HW_LD;
            HW_YELLOW: tload_val = YEL_LD;
            CN_GREEN:  tload_val = MAX_CN_LD;
            CN_YELLOW: tload_val = YEL_LD;
            PED_WALK:  tload_val = WALK_LD;
            default:   tload_val = ALLRED_LD;
        endcase
    end

    phase_timer #(
        .TW      (TW),
        .RST_VAL (ALLRED_LD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tload),
        .load_val (tload_val),
        .done     (tdone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ALL_RED_B;
        end else begin
            state <= state_nxt;
        end
    end

    // Cleared on the walk entry edge so the flag is low for the whole walk;
    // presses during the walk are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
        end else if (state_nxt == PED_WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_req && (state != PED_WALK)) begin
            ped_pending <= 1'b1;
        end
    end

    always_comb begin
        hgwy  = RED;
        cntry = RED;
        case (state)
            HW_GREEN:  hgwy  = GREEN;
            HW_YELLOW: hgwy  = YELLOW;
            CN_GREEN:  cntry = GREEN;
            CN_YELLOW: cntry = YELLOW;
            default: begin
                hgwy  = RED;
                cntry = RED;
            end
        endcase
    end

    assign walk        = (state == PED_WALK);
    assign ped_waiting = ped_pending;
    assign phase       = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg_req = 1'b0;
    logic [2:0] hgwy;
    logic [2:0] cntry;
    logic       walk;
    logic       ped_waiting;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .car_sensor  (car_sensor),
        .ped_req     (ped_req),
        .emerg_req   (emerg_req),
        .hgwy        (hgwy),
        .cntry       (cntry),
        .walk        (walk),
        .ped_waiting (ped_waiting),
        .phase       (phase)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_h(input logic [2:0] p);
        case (p)
            3'd0:    return 3'd2;
            3'd1:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] exp_c(input logic [2:0] p);
        case (p)
            3'd3:    return 3'd2;
            3'd4:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Check n consecutive cycles of phase p (with its light decode),
    // advancing one cycle after each check.
    task automatic run(input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("phase%0d_c%0d", p, i + 1), phase, p);
            chk($sformatf("hgwy_p%0d", p), hgwy, exp_h(p));
            chk($sformatf("cntry_p%0d", p), cntry, exp_c(p));
            chk($sformatf("walk_p%0d", p), walk, (p == 3'd6));
            @(negedge clk);
        end
    endtask

    int  yl;
    int  reds;
    bit  armed;
    bit  prev_green;
    bit  is_yel;
    bit  is_grn;

    initial begin
        // ---------------- reset held ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_phase", phase, 3'd5);
        chk("rst_hgwy", hgwy, 3'd0);
        chk("rst_cntry", cntry, 3'd0);
        chk("rst_walk", walk, 1'b0);
        chk("rst_pedw", ped_waiting, 1'b0);

        // ---------------- release, max-out cycle ----------------
        car_sensor = 1'b1;
        rst_n = 1'b1;
        run(3'd5, 4);
        run(3'd0, 8);
        run(3'd1, 6);
        run(3'd2, 4);
        run(3'd3, 16);
        run(3'd4, 6);
        run(3'd5, 4);

        // ---------------- gap-out ----------------
        run(3'd0, 8);
        run(3'd1, 6);
        run(3'd2, 4);
        run(3'd3, 2);
        car_sensor = 1'b0;      // during 3rd CN_GREEN cycle
        run(3'd3, 1);
        chk("gapout_cntry", cntry, 3'd1);
        run(3'd4, 6);
        run(3'd5, 4);

        // ---------------- pedestrian ----------------
        run(3'd0, 1);
        ped_req = 1'b1;         // HW_GREEN cycle 2
        chk("ped_pre", ped_waiting, 1'b0);
        @(negedge clk);
        ped_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("ped_wait_hold", ped_waiting, 1'b1);
            if (i < 6)       run(3'd0, 1);
            else if (i < 12) run(3'd1, 1);
            else             run(3'd2, 1);
        end
        for (int i = 0; i < 10; i++) begin
            ped_req = (i == 2);
            chk("ped_walk_clr", ped_waiting, 1'b0);
            run(3'd6, 1);
        end
        ped_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ped_drop", ped_waiting, 1'b0);
            run(3'd5, 1);
        end
        run(3'd0, 12);          // no demand: highway rests

        // ---------------- emergency ----------------
        car_sensor = 1'b1;
        run(3'd0, 1);
        run(3'd1, 6);
        run(3'd2, 4);
        run(3'd3, 4);
        emerg_req = 1'b1;       // CN_GREEN cycle 5
        run(3'd3, 1);
        run(3'd4, 6);
        run(3'd5, 4);
        run(3'd0, 20);
        emerg_req = 1'b0;
        run(3'd0, 1);
        run(3'd1, 6);
        run(3'd2, 4);

        // ---------------- asynchronous reset mid-cycle ----------------
        chk("pre_async", phase, 3'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_phase", phase, 3'd5);
        chk("async_cntry", cntry, 3'd0);
        chk("async_hgwy", hgwy, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(3'd5, 4);
        run(3'd0, 1);

        // ---------------- random safety soak ----------------
        rst_n = 1'b0;
        @(negedge clk);
        yl = 0; reds = 0; armed = 0; prev_green = 0;
        for (int i = 0; i < 10000; i++) begin
            chk("safety",
                ((hgwy == 3'd3) || (cntry == 3'd3) || (hgwy != 3'd0 && cntry != 3'd0)), 1'b0);
            if (!rst_n) begin
                yl = 0; reds = 0; armed = 0; prev_green = 0;
            end else begin
                is_yel = (hgwy == 3'd1) || (cntry == 3'd1);
                is_grn = (hgwy == 3'd2) || (cntry == 3'd2);
                if (is_yel) begin
                    yl++;
                end else if (yl != 0) begin
                    chk("yellow_len", yl, 6);
                    yl = 0;
                end
                if (hgwy == 3'd0 && cntry == 3'd0) reds++;
                if (is_grn) begin
                    if (!prev_green && armed) begin
                        n_cmp++;
                        assert (reds >= 4) else begin
                            n_err++;
                            $error("FAIL allred_gap: observed %0d expected >=4", reds);
                        end
                    end
                    reds = 0;
                    armed = 1;
                end
                prev_green = is_grn;
            end
            if ($urandom_range(0, 9) == 0)  car_sensor = ~car_sensor;
            if ($urandom_range(0, 39) == 0) emerg_req = ~emerg_req;
            ped_req = ($urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 1499) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
